fpr_wb_arbiter: RTL and testbench

FPR_WB_ARBITER -- requirements
Module: fpr_wb_arbiter

---
 rtl/fpr_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_fpr_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpr_wb_arbiter.sv
// Floating-point register-file write-back arbiter: one small FIFO per result
// source (FPU, LSU), round-robin onto a single FPR write port, plus a hazard query.
module fpr_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          fpu_valid,
  output logic          fpu_ready,
  input  logic [AW-1:0] fpu_addr,
  input  logic [DW-1:0] fpu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_data,
  output logic          fpr_we,
  output logic [AW-1:0] fpr_waddr,
  output logic [DW-1:0] fpr_wdata,
  input  logic [AW-1:0] q_addr,
  output logic          q_pending
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic SRC_FPU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // Source index 0 is the FPU, 1 is the LSU.
  logic [AW-1:0] r_addr [2][DEPTH];
  logic [DW-1:0] r_data [2][DEPTH];
  logic [PW-1:0] r_wp [2];
  logic [PW-1:0] r_rp [2];
  logic [CW-1:0] r_cnt [2];
  logic          r_last_grant;

  logic          w_valid  [2];
  logic [AW-1:0] w_in_addr[2];
  logic [DW-1:0] w_in_data[2];
  logic          w_ready  [2];
  logic          w_push   [2];
  logic          w_pop    [2];
  logic          w_nempty [2];
  logic          w_active;
  logic [PW-1:0] w_off;

  assign w_valid[0]   = fpu_valid;
  assign w_valid[1]   = lsu_valid;
  assign w_in_addr[0] = fpu_addr;
  assign w_in_addr[1] = lsu_addr;
  assign w_in_data[0] = fpu_data;
  assign w_in_data[1] = lsu_data;
  assign w_active     = !rst && !flush;

  // Handshake: a result transfers on a rising edge where valid && ready; ready
  // depends only on FIFO fullness, flush and rst, never on valid, and a full
  // FIFO refuses input even if its head is being written in the same cycle.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_nempty[s] = (r_cnt[s] != '0);
      w_ready[s]  = (r_cnt[s] != CW'(DEPTH)) && w_active;
      w_push[s]   = w_valid[s] && w_ready[s];
    end
    // On a tie the source that did not win last time gets the port.
    w_pop[0] = w_active && w_nempty[0] && (!w_nempty[1] || r_last_grant == SRC_LSU);
    w_pop[1] = w_active && w_nempty[1] && (!w_nempty[0] || r_last_grant == SRC_FPU);
  end

  assign fpu_ready = w_ready[0];
  assign lsu_ready = w_ready[1];

  always_comb begin
    fpr_we    = 1'b0;
    fpr_waddr = '0;
    fpr_wdata = '0;
    if (w_pop[0]) begin
      fpr_we    = 1'b1;
      fpr_waddr = r_addr[0][r_rp[0]];
      fpr_wdata = r_data[0][r_rp[0]];
    end else if (w_pop[1]) begin
      fpr_we    = 1'b1;
      fpr_waddr = r_addr[1][r_rp[1]];
      fpr_wdata = r_data[1][r_rp[1]];
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    q_pending = 1'b0;
    w_off     = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_off = PW'(i) - r_rp[s];
        if (!rst && (CW'(w_off) < r_cnt[s]) && (r_addr[s][i] == q_addr)) begin
          q_pending = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < 2; s++) begin
        r_wp[s]  <= '0;
        r_rp[s]  <= '0;
        r_cnt[s] <= '0;
      end
      if (rst) begin
        r_last_grant <= SRC_LSU;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) begin
          r_addr[s][r_wp[s]] <= w_in_addr[s];
          r_data[s][r_wp[s]] <= w_in_data[s];
          r_wp[s]            <= r_wp[s] + PW'(1);
        end
        if (w_pop[s]) begin
          r_rp[s] <= r_rp[s] + PW'(1);
        end
        if (w_push[s] && !w_pop[s]) begin
          r_cnt[s] <= r_cnt[s] + CW'(1);
        end else if (!w_push[s] && w_pop[s]) begin
          r_cnt[s] <= r_cnt[s] - CW'(1);
        end
      end
      if (w_pop[0]) begin
        r_last_grant <= SRC_FPU;
      end else if (w_pop[1]) begin
        r_last_grant <= SRC_LSU;
      end
    end
  end

endmodule

// File: tb/tb_fpr_wb_arbiter.sv
// Directed self-checking bench for fpr_wb_arbiter (DEPTH=2): reset, latency,
// round-robin under saturation, hazard query, flush and mid-operation reset.
module tb_fpr_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_addr;
  logic [31:0] fpu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        fpr_we;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wdata;
  logic [4:0]  q_addr;
  logic        q_pending;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] exp_f[$];
  logic [36:0] exp_l[$];

  fpr_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_addr(fpu_addr), .fpu_data(fpu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .fpr_we(fpr_we), .fpr_waddr(fpr_waddr), .fpr_wdata(fpr_wdata),
    .q_addr(q_addr), .q_pending(q_pending)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [4:0] fa, input logic [31:0] fd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    fpu_valid = fv; fpu_addr = fa; fpu_data = fd;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
  endtask

  task automatic reset_dut();
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Leaves FPU holding {11}, LSU holding {20,21}, last grant = FPU.
  task automatic fill3();
    drive(1'b1, 5'd10, 32'h0F0A, 1'b1, 5'd20, 32'h010A);
    next_cycle();
    drive(1'b1, 5'd11, 32'h0F0B, 1'b1, 5'd21, 32'h010B);
    #1;
    chk("fill_first_tie", fpr_waddr, 10);
    next_cycle();
  endtask

  int fcnt, lcnt, wr_k;
  logic is_fpu, saw_fd, saw_ld;
  logic [36:0] e;

  initial begin
    // Reset behaviour with active inputs
    rst = 1'b1; flush = 1'b0; q_addr = 5'd3;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
    next_cycle();
    #1;
    chk("rst_we", fpr_we, 0);
    chk("rst_waddr", fpr_waddr, 0);
    chk("rst_wdata", fpr_wdata, 0);
    chk("rst_fpu_ready", fpu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_q_pending", q_pending, 0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("post_rst_we", fpr_we, 0);
    chk("post_rst_fpu_ready", fpu_ready, 1);
    chk("post_rst_lsu_ready", lsu_ready, 1);
    chk("post_rst_q_pending", q_pending, 0);

    // Single push, write exactly one cycle later
    drive(1'b1, 5'd3, 32'h3F800000, 1'b0, 5'd0, 32'h0);
    #1;
    chk("single_n_we", fpr_we, 0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("single_n1_we", fpr_we, 1);
    chk("single_n1_waddr", fpr_waddr, 3);
    chk("single_n1_wdata", fpr_wdata, 32'h3F800000);
    chk("single_n1_q_pending", q_pending, 1);
    next_cycle();
    #1;
    chk("single_n2_we", fpr_we, 0);
    chk("single_n2_q_pending", q_pending, 0);

    // Both sources saturating for 8 cycles, then drain
    reset_dut();
    fcnt = 0; lcnt = 0; wr_k = 0; saw_fd = 1'b0; saw_ld = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(c < 8, 5'(8 + fcnt), 32'hF0000000 | 32'(fcnt),
            c < 8, 5'(16 + lcnt), 32'h10000000 | 32'(lcnt));
      #1;
      if (fpr_we) begin
        is_fpu = (fpr_wdata[31:28] == 4'hF);
        if (c >= 1 && c <= 7) chk("rr_alternate", is_fpu, (wr_k % 2) == 0);
        if (is_fpu) begin
          if (exp_f.size() == 0) chk("sb_fpu_extra", 1, 0);
          else begin e = exp_f.pop_front(); chk("sb_fpu", {fpr_waddr, fpr_wdata}, e); end
        end else begin
          if (exp_l.size() == 0) chk("sb_lsu_extra", 1, 0);
          else begin e = exp_l.pop_front(); chk("sb_lsu", {fpr_waddr, fpr_wdata}, e); end
        end
        wr_k++;
      end
      if (c < 8 && !fpu_ready) saw_fd = 1'b1;
      if (c < 8 && !lsu_ready) saw_ld = 1'b1;
      if (fpu_valid && fpu_ready) begin exp_f.push_back({fpu_addr, fpu_data}); fcnt++; end
      if (lsu_valid && lsu_ready) begin exp_l.push_back({lsu_addr, lsu_data}); lcnt++; end
      next_cycle();
    end
    #1;
    chk("sat_fpu_accepted", fcnt, 5);
    chk("sat_lsu_accepted", lcnt, 5);
    chk("sat_writes", wr_k, 10);
    chk("sat_fpu_left", exp_f.size(), 0);
    chk("sat_lsu_left", exp_l.size(), 0);
    chk("sat_fpu_ready_drop", saw_fd, 1);
    chk("sat_lsu_ready_drop", saw_ld, 1);
    chk("sat_idle_we", fpr_we, 0);

    // Hazard query on FPU entries 5 and 6, then f0 write
    reset_dut();
    drive(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'h0);
    q_addr = 5'd5;
    #1;
    chk("hz_before_push", q_pending, 0);
    chk("hz_fpu_ready", fpu_ready, 1);
    next_cycle();
    drive(1'b1, 5'd6, 32'hA6, 1'b0, 5'd0, 32'h0);
    q_addr = 5'd6;
    #1;
    chk("hz_6_not_yet", q_pending, 0);
    chk("hz_write5_addr", fpr_waddr, 5);
    q_addr = 5'd5;
    #1;
    chk("hz_5_head", q_pending, 1);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    q_addr = 5'd6;
    #1;
    chk("hz_6_head", q_pending, 1);
    chk("hz_write6_data", fpr_wdata, 32'hA6);
    q_addr = 5'd7;
    #1;
    chk("hz_7_absent", q_pending, 0);
    next_cycle();
    q_addr = 5'd6;
    #1;
    chk("hz_6_done", q_pending, 0);
    chk("hz_idle_we", fpr_we, 0);
    drive(1'b1, 5'd0, 32'h00000F00, 1'b0, 5'd0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    q_addr = 5'd0;
    #1;
    chk("f0_we", fpr_we, 1);
    chk("f0_waddr", fpr_waddr, 0);
    chk("f0_wdata", fpr_wdata, 32'h00000F00);
    chk("f0_q_pending", q_pending, 1);
    next_cycle();
    #1;
    chk("f0_empty_q_pending", q_pending, 0);

    // Flush with entries queued; last grant must survive it
    reset_dut();
    fill3();
    flush = 1'b1;
    drive(1'b1, 5'd12, 32'h0F0C, 1'b1, 5'd22, 32'h010C);
    q_addr = 5'd21;
    #1;
    chk("flush_we", fpr_we, 0);
    chk("flush_fpu_ready", fpu_ready, 0);
    chk("flush_lsu_ready", lsu_ready, 0);
    chk("flush_q_pending", q_pending, 1);
    next_cycle();
    flush = 1'b0;
    drive(1'b1, 5'd13, 32'h0F0D, 1'b1, 5'd23, 32'h010D);
    #1;
    chk("aflush_we", fpr_we, 0);
    chk("aflush_q_pending", q_pending, 0);
    chk("aflush_fpu_ready", fpu_ready, 1);
    chk("aflush_lsu_ready", lsu_ready, 1);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("aflush_tie_lsu", fpr_waddr, 23);
    next_cycle();
    #1;
    chk("aflush_then_fpu", fpr_waddr, 13);
    next_cycle();
    #1;
    chk("aflush_idle_we", fpr_we, 0);

    // Reset mid-operation with three entries queued
    reset_dut();
    fill3();
    rst = 1'b1;
    drive(1'b1, 5'd12, 32'h0F0C, 1'b1, 5'd22, 32'h010C);
    q_addr = 5'd21;
    #1;
    chk("mrst_we", fpr_we, 0);
    chk("mrst_q_pending", q_pending, 0);
    next_cycle();
    #1;
    chk("mrst_we2", fpr_we, 0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("amrst_we", fpr_we, 0);
    chk("amrst_q_pending", q_pending, 0);
    drive(1'b1, 5'd14, 32'h0F0E, 1'b1, 5'd24, 32'h010E);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("amrst_tie_fpu", fpr_waddr, 14);
    next_cycle();
    #1;
    chk("amrst_then_lsu", fpr_waddr, 24);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
